// File: rtl/pool_pkg.sv
// Shared types and width helpers for the 2x2 stride-2 pooling engine.
package pool_pkg;

    typedef enum logic {
        POOL_AVG = 1'b0,
        POOL_MAX = 1'b1
    } pool_mode_e;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } pool_state_e;

    function automatic int part_w(input int data_w);
        return data_w + 1;
    endfunction

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Holds one row of horizontal pair results until the matching odd row arrives.
module pool_line_buf #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 14,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pool2x2_stream.sv
// Streaming 2x2 stride-2 average/max pooling with ready/valid on both sides.
module pool2x2_stream
    import pool_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_pixel,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_pixel,
    output logic              busy,
    output logic              finish
);

    localparam int PW   = part_w(DATA_W);
    localparam int CW   = cnt_w(IMG_W);
    localparam int RW   = cnt_w(IMG_H);
    localparam int LB_N = IMG_W / 2;
    localparam int AW   = cnt_w(LB_N);

    pool_state_e state, state_nx;
    pool_mode_e  mode_q;

    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic [DATA_W-1:0] hold_reg;
    logic              acc, last_px, lb_we, emit;
    logic [AW-1:0]     lb_idx;

    logic signed [PW-1:0]     ha, hb, pair, lb_rd;
    logic signed [DATA_W+1:0] la, pa, sum4, shr;
    logic [DATA_W-1:0]        res;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (acc && last_px) state_nx = DRAIN;
            DRAIN:   if (!out_valid || out_ready) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state == RUN) || (state == DRAIN);
        finish   = (state == DONE);
        in_ready = (state == RUN) && (!out_valid || out_ready);
    end

    assign acc     = in_valid && in_ready;
    assign last_px = (col == CW'(IMG_W - 1)) && (row == RW'(IMG_H - 1));
    assign lb_idx  = AW'(col >> 1);
    assign lb_we   = acc && col[0] && !row[0];
    assign emit    = acc && col[0] && row[0];

    assign ha = {hold_reg[DATA_W-1], hold_reg};
    assign hb = {in_pixel[DATA_W-1], in_pixel};

    always_comb begin
        pair = ha + hb;
        if (mode_q == POOL_MAX) pair = (ha > hb) ? ha : hb;
    end

    // Four-pixel sum needs two guard bits so the floor shift cannot overflow.
    assign la   = {lb_rd[PW-1], lb_rd};
    assign pa   = {pair[PW-1], pair};
    assign sum4 = la + pa;
    assign shr  = sum4 >>> 2;

    always_comb begin
        res = shr[DATA_W-1:0];
        if (mode_q == POOL_MAX)
            res = (lb_rd > pair) ? lb_rd[DATA_W-1:0] : pair[DATA_W-1:0];
    end

    pool_line_buf #(
        .WIDTH (PW),
        .DEPTH (LB_N),
        .AW    (AW)
    ) u_line_buf (
        .clk   (clk),
        .we    (lb_we),
        .waddr (lb_idx),
        .wdata (pair),
        .raddr (lb_idx),
        .rdata (lb_rd)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col      <= '0;
            row      <= '0;
            hold_reg <= '0;
            mode_q   <= POOL_AVG;
        end else if (state == IDLE && start) begin
            col    <= '0;
            row    <= '0;
            mode_q <= pool_mode_e'(mode);
        end else if (acc) begin
            if (!col[0]) hold_reg <= in_pixel;
            if (col == CW'(IMG_W - 1)) begin
                col <= '0;
                row <= (row == RW'(IMG_H - 1)) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_pixel <= '0;
        end else if (emit) begin
            out_valid <= 1'b1;
            out_pixel <= res;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pool2x2_stream.sv
// Directed bench for pool2x2_stream on a 4x4 and a 5x5 instance.
module tb_pool2x2_stream;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic        sel = 1'b0;
    logic [15:0] in_pixel = '0;

    logic        ir4, ov4, bz4, fn4;
    logic        ir5, ov5, bz5, fn5;
    logic [15:0] op4, op5;
    logic        ir, ov, bz, fn;
    logic [15:0] op;

    pool2x2_stream #(.DATA_W(16), .IMG_W(4), .IMG_H(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .start     (start && !sel),
        .mode      (mode),
        .in_valid  (in_valid && !sel),
        .in_ready  (ir4),
        .in_pixel  (in_pixel),
        .out_valid (ov4),
        .out_ready (out_ready),
        .out_pixel (op4),
        .busy      (bz4),
        .finish    (fn4)
    );

    pool2x2_stream #(.DATA_W(16), .IMG_W(5), .IMG_H(5)) dut5 (
        .clk       (clk),
        .rst       (rst),
        .start     (start && sel),
        .mode      (mode),
        .in_valid  (in_valid && sel),
        .in_ready  (ir5),
        .in_pixel  (in_pixel),
        .out_valid (ov5),
        .out_ready (out_ready),
        .out_pixel (op5),
        .busy      (bz5),
        .finish    (fn5)
    );

    assign ir = sel ? ir5 : ir4;
    assign ov = sel ? ov5 : ov4;
    assign bz = sel ? bz5 : bz4;
    assign fn = sel ? fn5 : fn4;
    assign op = sel ? op5 : op4;

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    int px[25];
    int ex[4];
    int got[$];

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic run_frame(input bit s, input bit m, input int n,
                             input int stall_at, input int stall_len,
                             input int nexp, input string name);
        int idx, nout, lin, lout, rem, efc;
        bit fin;
        idx  = 0;
        nout = 0;
        lin  = -10;
        lout = -10;
        rem  = stall_len;
        fin  = 1'b0;
        got.delete();
        @(negedge clk);
        sel   = s;
        start = 1'b1;
        mode  = m;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 400 && !fin; c++) begin
            in_valid = (idx < n);
            in_pixel = (idx < n) ? 16'(px[idx]) : 16'd0;
            out_ready = !(rem > 0 && nout == stall_at && ov);
            #1;
            if (c == 0) chk({name, "_busy_start"}, int'(bz), 1);
            if (!out_ready) begin
                chk({name, "_stall_hold"}, int'($signed(op)), ex[stall_at]);
                chk({name, "_stall_in_ready"}, int'(ir), 0);
                rem--;
            end
            if (fn) begin
                efc = (lout + 1 > lin + 2) ? lout + 1 : lin + 2;
                chk({name, "_finish_cycle"}, c, efc);
                chk({name, "_busy_at_finish"}, int'(bz), 0);
                fin = 1'b1;
            end else begin
                if (ov && out_ready) begin
                    got.push_back(int'($signed(op)));
                    nout++;
                    lout = c;
                end
                if (in_valid && ir) begin
                    idx++;
                    lin = c;
                end
            end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk({name, "_finish_seen"}, int'(fin), 1);
        #1;
        chk({name, "_finish_pulse"}, int'(fn), 0);
        chk({name, "_idle_ready"}, int'(ir), 0);
        chk({name, "_inputs"}, idx, n);
        chk({name, "_out_count"}, got.size(), nexp);
        for (int i = 0; i < nexp; i++)
            chk($sformatf("%s_out%0d", name, i),
                (i < got.size()) ? got[i] : -99999, ex[i]);
    endtask

    initial begin
        int neg[16];
        neg = '{-1, -2, -32768, -5,
                -3, -4, -7, -9,
                100, -100, 0, 0,
                32767, 32767, -32768, -32768};

        #1 rst = 1'b1;
        #1;
        chk("rst_in_ready", int'(ir4), 0);
        chk("rst_out_valid", int'(ov4), 0);
        chk("rst_busy", int'(bz4), 0);
        chk("rst_finish", int'(fn4), 0);
        chk("rst_out_pixel", int'(op4), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 25; i++) px[i] = i + 1;
        ex = '{3, 5, 11, 13};
        run_frame(1'b0, 1'b0, 16, -1, 0, 4, "avg4");

        ex = '{6, 8, 14, 16};
        run_frame(1'b0, 1'b1, 16, -1, 0, 4, "max4");

        for (int i = 0; i < 16; i++) px[i] = neg[i];
        ex = '{-3, -8198, 16383, -16384};
        run_frame(1'b0, 1'b0, 16, -1, 0, 4, "avgneg");
        ex = '{-1, -5, 32767, 0};
        run_frame(1'b0, 1'b1, 16, -1, 0, 4, "maxneg");

        for (int i = 0; i < 25; i++) px[i] = i + 1;
        ex = '{3, 5, 11, 13};
        run_frame(1'b0, 1'b0, 16, 0, 5, 4, "stall");

        ex = '{4, 6, 14, 16};
        run_frame(1'b1, 1'b0, 25, -1, 0, 4, "odd5");

        @(negedge clk);
        sel   = 1'b0;
        start = 1'b1;
        mode  = 1'b0;
        @(negedge clk);
        start     = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_pixel = 16'(i + 1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        #1;
        chk("mid_out_valid", int'(ov4), 1);
        chk("mid_out_pixel", int'(op4), 3);
        chk("mid_in_ready", int'(ir4), 0);
        rst = 1'b1;
        #1;
        chk("mrst_out_valid", int'(ov4), 0);
        chk("mrst_out_pixel", int'(op4), 0);
        chk("mrst_busy", int'(bz4), 0);
        chk("mrst_in_ready", int'(ir4), 0);
        chk("mrst_finish", int'(fn4), 0);
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;

        ex = '{3, 5, 11, 13};
        run_frame(1'b0, 1'b0, 16, -1, 0, 4, "after_rst");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
